// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer
//
// Frame-level controller that feeds a 2x2 max pooler. Pixels arrive in raster
// order over a valid/ready stream. Each even (top) row is stored in a line
// buffer. The pixels of the following odd (bottom) row are paired with the
// buffered pixels above them and re-emitted in 2x2 block order: top-left,
// top-right, bottom-left, bottom-right. The pooler is held in reset whenever no
// frame is active, so every frame starts aligned to a block boundary.
//
// Ports
//   clk, reset      : clock; asynchronous active-high reset
//   start           : begin a frame (sampled only in IDLE)
//   cfg_width       : frame width in pixels (even, 2..W_MAX), latched on start
//   cfg_height      : frame height in rows (even, >= 2), latched on start
//   s_valid/s_data  : input pixel stream (signed N-bit)
//   s_ready         : sequencer accepts a pixel this cycle
//   p_valid/p_data  : pixel stream to the pooler (valid_in / din)
//   pool_rst        : reset for the pooler, high outside a frame
//   busy            : frame in progress
//   done            : one-cycle pulse at frame end
//   cfg_err         : one-cycle pulse when a start is rejected
module pool_window_sequencer #(
    parameter int N      = 16,
    parameter int W_MAX  = 64,
    parameter int H_BITS = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(W_MAX+1)-1:0]   cfg_width,
    input  logic [H_BITS-1:0]            cfg_height,
    input  logic                         s_valid,
    input  logic signed [N-1:0]          s_data,
    output logic                         s_ready,
    output logic                         p_valid,
    output logic signed [N-1:0]          p_data,
    output logic                         pool_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int CW = $clog2(W_MAX + 1);
    localparam int AW = (W_MAX > 1) ? $clog2(W_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, ROW_TOP, ROW_BOT_L, ROW_BOT_R, E0, E1, E2, E3
    } state_t;

    state_t                state;
    logic [CW-1:0]         width;
    logic [H_BITS-1:0]     height;
    logic [CW-1:0]         col;
    logic [H_BITS-1:0]     row;
    logic signed [N-1:0]   linebuf [W_MAX];
    logic signed [N-1:0]   hold_l;
    logic signed [N-1:0]   hold_r;

    logic [CW-1:0] col_m1;
    logic          xfer;
    logic          cfg_ok;
    logic          last_col;
    logic          last_row;

    assign xfer     = s_valid && s_ready;
    assign col_m1   = col - CW'(1);
    assign last_col = (col == width - CW'(1));
    assign last_row = (row == height - H_BITS'(1));
    assign cfg_ok   = !cfg_width[0] && (cfg_width >= CW'(2)) &&
                      (cfg_width <= CW'(W_MAX)) &&
                      !cfg_height[0] && (cfg_height >= H_BITS'(2));

    // Pixel storage: no reset needed, every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (state == ROW_TOP && xfer)
            linebuf[col[AW-1:0]] <= s_data;
        if (state == ROW_BOT_L && xfer)
            hold_l <= s_data;
        if (state == ROW_BOT_R && xfer)
            hold_r <= s_data;
    end

    // Control FSM. Outputs are assigned on the same edge as the state change,
    // so each output register always reflects the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            width    <= '0;
            height   <= '0;
            col      <= '0;
            row      <= '0;
            s_ready  <= 1'b0;
            p_valid  <= 1'b0;
            p_data   <= '0;
            pool_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            width    <= cfg_width;
                            height   <= cfg_height;
                            col      <= '0;
                            row      <= '0;
                            state    <= ROW_TOP;
                            s_ready  <= 1'b1;
                            busy     <= 1'b1;
                            pool_rst <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ROW_TOP: begin
                    if (xfer) begin
                        if (last_col) begin
                            col   <= '0;
                            row   <= row + H_BITS'(1);
                            state <= ROW_BOT_L;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ROW_BOT_L: begin
                    if (xfer) begin
                        col   <= col + CW'(1);
                        state <= ROW_BOT_R;
                    end
                end
                ROW_BOT_R: begin
                    // col is odd here: the block's top pixels sit at col-1 and col.
                    if (xfer) begin
                        state   <= E0;
                        s_ready <= 1'b0;
                        p_valid <= 1'b1;
                        p_data  <= linebuf[col_m1[AW-1:0]];
                    end
                end
                E0: begin
                    state  <= E1;
                    p_data <= linebuf[col[AW-1:0]];
                end
                E1: begin
                    state  <= E2;
                    p_data <= hold_l;
                end
                E2: begin
                    state  <= E3;
                    p_data <= hold_r;
                end
                E3: begin
                    p_valid <= 1'b0;
                    if (last_col && last_row) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        pool_rst <= 1'b1;
                        state    <= IDLE;
                    end else if (last_col) begin
                        col     <= '0;
                        row     <= row + H_BITS'(1);
                        s_ready <= 1'b1;
                        state   <= ROW_TOP;
                    end else begin
                        col     <= col + CW'(1);
                        s_ready <= 1'b1;
                        state   <= ROW_BOT_L;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pool_window_sequencer.md
# pool_window_sequencer

- Frame-level controller for the 2x2 max pooler (`pooler_max2x2`, N-bit signed).
- Accepts a feature map in raster order (row by row, left to right) over a valid/ready stream.
- Buffers one even row in a line buffer and reorders pixels into 2x2 block order for the pooler: top-left, top-right, bottom-left, bottom-right.
- Holds the pooler in reset outside a frame, so every frame starts block-aligned.

## Interface

Parameters:
- `N`, 16: pixel width, signed.
- `W_MAX`, 64: maximum frame width in pixels; even; line-buffer depth.
- `H_BITS`, 10: width of the height configuration field.

Ports:
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: begin a frame; sampled only in IDLE.
- `cfg_width` input $clog2(W_MAX+1): frame width; latched on accepted start.
- `cfg_height` input H_BITS: frame height; latched on accepted start.
- `s_valid` input 1: input pixel valid.
- `s_data` input N: input pixel, signed.
- `s_ready` output 1: sequencer can accept a pixel.
- `p_valid` output 1: drives the pooler `valid_in`.
- `p_data` output N: drives the pooler `din`.
- `pool_rst` output 1: drives the pooler `reset`.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse at frame end.
- `cfg_err` output 1: one-cycle pulse when a start is rejected.

## Operation

Configuration:
- A configuration is legal when `cfg_width` is even and in 2..W_MAX, and `cfg_height` is even and at least 2.
- `start` in IDLE with a legal configuration latches width and height, clears `col` and `row`, and enters ROW_TOP.
- `start` in IDLE with an illegal configuration pulses `cfg_err`; the block stays in IDLE.
- `start` in any other state is ignored.

States:
- IDLE: `s_ready`=0, `pool_rst`=1, `busy`=0.
- ROW_TOP (even row):
  - `s_ready`=1.
  - Each handshake writes `linebuf[col]` and increments `col`.
  - At `col`=width-1: `col` resets to 0, `row` increments, next state is ROW_BOT.
- ROW_BOT_L (bottom row, even column):
  - `s_ready`=1.
  - A handshake latches `s_data` into `hold_l`, increments `col`, and enters ROW_BOT_R.
- ROW_BOT_R (bottom row, odd column):
  - `s_ready`=1.
  - A handshake latches `s_data` into `hold_r` and enters E0.
- E0..E3 (emit): `s_ready`=0, `p_valid`=1.
  - E0: `p_data`=`linebuf[col-1]`.
  - E1: `p_data`=`linebuf[col]`.
  - E2: `p_data`=`hold_l`.
  - E3: `p_data`=`hold_r`.
- Leaving E3:
  - If `col`=width-1 and `row`=height-1: pulse `done`, go to IDLE.
  - Else if `col`=width-1: `col`=0, `row`++, go to ROW_TOP.
  - Else: `col`++, go to ROW_BOT_L.
- ROW_BOT denotes ROW_BOT_L.

Outputs and arithmetic:
- `pool_rst`=0 in every state except IDLE.
- `busy`=1 in every state except IDLE.
- `p_data` is passed through unchanged; no arithmetic on pixels.
- `p_data` holds its last value when `p_valid`=0.
- The line buffer is a register array of W_MAX entries with combinational read. Its contents are undefined after reset and are never read before being written.

## Timing

Reset values:
- `s_ready`=0, `p_valid`=0, `p_data`=0, `busy`=0, `done`=0, `cfg_err`=0, `pool_rst`=1.
- State returns to IDLE.

Outputs:
- All outputs are registered (Moore).

Start:
- `start` accepted at edge T: `busy`=1, `pool_rst`=0, `s_ready`=1 from T+1.
- `cfg_err` rejection: pulse at T+1.

Emit:
- Handshake of the bottom-right pixel at edge T: `p_valid`=1 and `s_ready`=0 for cycles T+1..T+4; `s_ready` returns to 1 at T+5 if the frame continues.
- The pooler's `valid_out` rises at T+5.
- `done` is high in cycle T+5 after the last block; `busy` drops to 0 in the same cycle; `pool_rst` returns to 1 in the same cycle.

Throughput:
- Top rows: 1 pixel/cycle.
- Bottom rows: 2 pixels per 6 cycles.

Handshake rules:
- A transfer occurs only when `s_valid` and `s_ready` are both high at a rising edge.
- `s_valid` gaps stall the state and counters with no side effects.
- `p_valid` is never asserted outside E0..E3.

Boundary conditions:
- Width 2: one block per row pair.
- Width W_MAX: `col` reaches W_MAX-1 without overflow.
- A reset asserted mid-frame (including mid-emit) aborts immediately to the reset values; no `done` is issued.
- `start` held high through a whole frame starts a new frame on the first IDLE cycle after `done`.

## Test plan

- Frame 4x2, rows {1,5,2,8} and {3,-4,7,0}.
  - Response: `p_data` sequence 1,5,3,-4 then 2,8,7,0.
  - Pooler outputs 5 then 8.
  - `done` pulses once; 8 `p_valid` cycles total.
- Same frame with `s_valid` randomly low ~50%.
  - Response: identical `p_data` sequence.
  - `s_ready` low exactly during the 4-cycle emits; no extra `p_valid`.
- `start` with `cfg_width`=3, then `cfg_height`=0, then `cfg_width`=W_MAX+2.
  - Response: `cfg_err` pulses each time; `busy` stays 0; `pool_rst` stays 1.
- `start` pulsed mid-frame.
  - Response: ignored; frame completes with a normal single `done`.
- Reset asserted during E2 of the first block, followed by a fresh 2x2 frame {9,-1 / 4,6}.
  - Response: all outputs return to their reset values during reset.
  - Next frame emits 9,-1,4,6; pooler outputs 9.
- Frame W_MAX x 4 with ramp data (pixel = row*W_MAX+col).
  - Response: W_MAX/2 x 2 = 64 blocks (W_MAX=64) in raster block order.
  - Each pooler output equals its block's bottom-right ramp value.
